// File: rtl/beam_reg_commit.sv
// Defers CPU writes to the beam-timing registers ($1C0-$1E4) and commits them as one burst
// at end of frame; all other register writes pass straight through to the beamcounter.
module beam_reg_commit #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          _reset,
   input  logic          clk7_en,
   input  logic          defer_en,
   input  logic          cpu_wr,
   input  logic [7:0]    cpu_reg_address_in,
   input  logic [15:0]   cpu_data_in,
   input  logic          eof,
   output logic [7:0]    reg_address_out,
   output logic [15:0]   data_out,
   output logic          wr_out,
   output logic          busy,
   output logic [AW:0]   pending,
   output logic          overflow
);

   typedef enum logic [1:0] {IDLE, ARMED, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            defer_q, defer_d;
   logic            wr_q, wr_d;
   logic [7:0]      addr_q, addr_d;
   logic [15:0]     data_q, data_d;
   logic [23:0]     mem_q [DEPTH];

   logic in_range, deferred, clr_cmd, pass, full, push, pop, flush;

   always_comb begin
      in_range = (cpu_reg_address_in >= 8'hE0) && (cpu_reg_address_in <= 8'hF2);
      deferred = cpu_wr && defer_en && in_range;
      clr_cmd  = cpu_wr && !deferred && (cpu_reg_address_in == 8'hFF);
      pass     = cpu_wr && !deferred && !clr_cmd;
      full     = (count_q == (AW+1)'(DEPTH));
      push     = deferred && !full;
      // A pass-through write takes the output port; the drain simply stalls a slot.
      pop      = (state_q == DRAIN) && !pass && (count_q != '0);
      flush    = defer_q && !defer_en;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wr_d     = 1'b0;
      defer_d  = defer_en;
      state_d  = state_q;

      if (pass) begin
         wr_d   = 1'b1;
         addr_d = cpu_reg_address_in;
         data_d = cpu_data_in;
      end else if (pop) begin
         wr_d     = 1'b1;
         addr_d   = mem_q[rd_ptr_q][23:16];
         data_d   = mem_q[rd_ptr_q][15:0];
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      if (push)
         wr_ptr_d = wr_ptr_q + AW'(1);

      if (deferred && full)
         ovf_d = 1'b1;
      else if (clr_cmd)
         ovf_d = 1'b0;

      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

      case (state_q)
         IDLE:    if (push) state_d = ARMED;
         ARMED:   if (eof || flush) state_d = DRAIN;
         DRAIN:   if (count_d == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         defer_q  <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else if (clk7_en) begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         defer_q  <= defer_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   // Storage needs no reset: the pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (clk7_en && push)
         mem_q[wr_ptr_q] <= {cpu_reg_address_in, cpu_data_in};
   end

   assign reg_address_out = addr_q;
   assign data_out        = data_q;
   assign wr_out          = wr_q;
   assign busy            = (state_q != IDLE);
   assign pending         = count_q;
   assign overflow        = ovf_q;

endmodule

// File: tb/tb_beam_reg_commit.sv
// Bench for beam_reg_commit: queue-based reference model compared every 7MHz slot,
// plus directed scenarios with literal expectations.
module tb_beam_reg_commit;

   logic        clk = 1'b0;
   logic        _reset = 1'b0;
   logic        clk7_en = 1'b0;
   logic        defer_en = 1'b0;
   logic        cpu_wr = 1'b0;
   logic [7:0]  cpu_reg_address_in = '0;
   logic [15:0] cpu_data_in = '0;
   logic        eof = 1'b0;
   logic [7:0]  reg_address_out;
   logic [15:0] data_out;
   logic        wr_out;
   logic        busy;
   logic [4:0]  pending;
   logic        overflow;

   int checks = 0;
   int failures = 0;
   logic [1:0] div = '0;

   beam_reg_commit #(.DEPTH(16), .AW(4)) dut (
      .clk(clk), ._reset(_reset), .clk7_en(clk7_en), .defer_en(defer_en),
      .cpu_wr(cpu_wr), .cpu_reg_address_in(cpu_reg_address_in), .cpu_data_in(cpu_data_in),
      .eof(eof), .reg_address_out(reg_address_out), .data_out(data_out), .wr_out(wr_out),
      .busy(busy), .pending(pending), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      div     <= div + 2'd1;
      clk7_en <= (div == 2'd3);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference model: a plain queue of pending writes plus a "committing" flag.
   logic [23:0] mq[$];
   logic [23:0] log_q[$];
   logic        m_commit = 1'b0;
   logic        m_prev = 1'b0;
   logic        m_ovf = 1'b0;

   task automatic model_reset();
      mq.delete();
      m_commit = 1'b0;
      m_prev   = 1'b0;
      m_ovf    = 1'b0;
   endtask

   logic        s_wr, s_def, s_eof, s_dfr, e_wr;
   logic [7:0]  s_a, e_a;
   logic [15:0] s_d, e_d;
   int          n0;

   always @(posedge clk) begin
      if (clk7_en && _reset) begin
         s_wr = cpu_wr; s_a = cpu_reg_address_in; s_d = cpu_data_in;
         s_def = defer_en; s_eof = eof;
         n0 = mq.size();
         s_dfr = s_wr && s_def && (s_a >= 8'hE0) && (s_a <= 8'hF2);
         e_wr = 1'b0;
         if (s_wr && !s_dfr) begin
            if (s_a == 8'hFF) m_ovf = 1'b0;
            else begin e_wr = 1'b1; e_a = s_a; e_d = s_d; end
         end else if (m_commit && n0 > 0) begin
            {e_a, e_d} = mq.pop_front();
            e_wr = 1'b1;
         end
         if (s_dfr) begin
            if (n0 == 16) m_ovf = 1'b1;
            else mq.push_back({s_a, s_d});
         end
         if (!m_commit && n0 > 0 && (s_eof || (m_prev && !s_def))) m_commit = 1'b1;
         if (mq.size() == 0) m_commit = 1'b0;
         m_prev = s_def;
         #1;
         if (_reset) begin
            chk("model_wr_out", 32'(wr_out), 32'(e_wr));
            if (e_wr) begin
               chk("model_addr", 32'(reg_address_out), 32'(e_a));
               chk("model_data", 32'(data_out), 32'(e_d));
            end
            chk("model_pending", 32'(pending), 32'(mq.size()));
            chk("model_busy", 32'(busy), 32'(mq.size() > 0));
            chk("model_overflow", 32'(overflow), 32'(m_ovf));
            if (wr_out) log_q.push_back({reg_address_out, data_out});
         end
      end
   end

   task automatic tick();
      do @(posedge clk); while (!clk7_en);
      #2;
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      cpu_wr = 1'b1; cpu_reg_address_in = a; cpu_data_in = d;
      tick();
      cpu_wr = 1'b0;
   endtask

   task automatic eof_tick();
      eof = 1'b1;
      tick();
      eof = 1'b0;
   endtask

   task automatic chk_log(input string nm, input int idx, input logic [23:0] exp);
      chk(nm, (idx < log_q.size()) ? 32'(log_q[idx]) : 32'hFFFF_FFFF, 32'(exp));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #23;
      chk("rst_wr_out", 32'(wr_out), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_addr_data", {8'd0, reg_address_out, data_out}, 32'd0);
      model_reset();
      _reset = 1'b1;
      tick();

      // pass-through
      wr(8'hE0, 16'h00E3);
      chk("pt_wr_out", 32'(wr_out), 32'd1);
      chk("pt_addr_data", {8'd0, reg_address_out, data_out}, 32'h00E0_00E3);
      chk("pt_pending", 32'(pending), 32'd0);
      tick();
      chk("pt_wr_one_slot", 32'(wr_out), 32'd0);

      // deferred commit
      defer_en = 1'b1;
      tick();
      log_q.delete();
      wr(8'hE0, 16'h00E3);
      wr(8'hE4, 16'h0138);
      wr(8'hEE, 16'h0020);
      tick(); tick();
      chk("def_no_wr", 32'(log_q.size()), 32'd0);
      chk("def_pending", 32'(pending), 32'd3);
      chk("def_busy", 32'(busy), 32'd1);
      eof_tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("def_wr_consec", 32'(wr_out), 32'd1);
      end
      chk("def_busy_fall", 32'(busy), 32'd0);
      chk_log("def_log0", 0, 24'hE0_00E3);
      chk_log("def_log1", 1, 24'hE4_0138);
      chk_log("def_log2", 2, 24'hEE_0020);

      // arbitration
      log_q.delete();
      wr(8'hE0, 16'h1111);
      wr(8'hE2, 16'h2222);
      wr(8'hE4, 16'h3333);
      eof_tick();
      tick();
      wr(8'h80, 16'h0200);
      chk("arb_pt_now", {8'd0, reg_address_out, data_out}, 32'h0080_0200);
      tick(); tick(); tick();
      chk("arb_count", 32'(log_q.size()), 32'd4);
      chk_log("arb_log0", 0, 24'hE0_1111);
      chk_log("arb_log1", 1, 24'h80_0200);
      chk_log("arb_log2", 2, 24'hE2_2222);
      chk_log("arb_log3", 3, 24'hE4_3333);

      // eof in the same slot as the first push does not commit; push+pop keeps count
      log_q.delete();
      cpu_wr = 1'b1; cpu_reg_address_in = 8'hE0; cpu_data_in = 16'h5A5A; eof = 1'b1;
      tick();
      cpu_wr = 1'b0; eof = 1'b0;
      tick(); tick();
      chk("eofpush_wait", 32'(log_q.size()), 32'd0);
      chk("eofpush_pending", 32'(pending), 32'd1);
      eof_tick();
      wr(8'hE2, 16'hA5A5);
      chk("pushpop_pending", 32'(pending), 32'd1);
      tick(); tick();
      chk_log("eofpush_log0", 0, 24'hE0_5A5A);
      chk_log("eofpush_log1", 1, 24'hE2_A5A5);
      chk("eofpush_idle", 32'(busy), 32'd0);

      // overflow
      log_q.delete();
      for (int i = 0; i < 17; i++)
         wr(8'hE0 + 8'(i % 19), 16'h1000 + 16'(i));
      chk("ovf_pending", 32'(pending), 32'd16);
      chk("ovf_flag", 32'(overflow), 32'd1);
      eof_tick();
      for (int i = 0; i < 18; i++) tick();
      chk("ovf_committed", 32'(log_q.size()), 32'd16);
      chk_log("ovf_first", 0, 24'hE0_1000);
      chk_log("ovf_last", 15, 24'hEF_100F);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      wr(8'hFF, 16'h0000);
      chk("ovf_clear", 32'(overflow), 32'd0);
      chk("ovf_clear_no_wr", 32'(wr_out), 32'd0);

      // flush on defer_en falling
      log_q.delete();
      wr(8'hE6, 16'hAAAA);
      wr(8'hE8, 16'hBBBB);
      tick();
      defer_en = 1'b0;
      tick(); tick(); tick();
      chk("flush_count", 32'(log_q.size()), 32'd2);
      chk_log("flush_log0", 0, 24'hE6_AAAA);
      chk_log("flush_log1", 1, 24'hE8_BBBB);

      // reset mid-drain
      defer_en = 1'b1;
      tick();
      log_q.delete();
      wr(8'hEA, 16'h0001);
      wr(8'hEC, 16'h0002);
      wr(8'hEE, 16'h0003);
      wr(8'hF0, 16'h0004);
      eof_tick();
      tick();
      chk("rmd_first_issued", 32'(wr_out), 32'd1);
      #5;
      _reset = 1'b0;
      model_reset();
      #1;
      chk("rmd_wr_out", 32'(wr_out), 32'd0);
      chk("rmd_pending", 32'(pending), 32'd0);
      chk("rmd_busy", 32'(busy), 32'd0);
      repeat (8) @(posedge clk);
      #3;
      _reset = 1'b1;
      log_q.delete();
      for (int i = 0; i < 6; i++) tick();
      chk("rmd_no_writes", 32'(log_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
